rect_raster_core: RTL and testbench

- Downstream stage of the rectangle copy controller in the brus16 GPU path.
- Captures the 16-bit rectangle word stream (copy data plus copy reset) into a rectangle register file.
- For each incoming pixel coordinate from the video timing unit, produces the colour of the topmost covering rectangle, or the background colour.
- Output feeds the video DAC/encoder stage.

---
 rtl/brus16_gpu_pkg.sv | 50 +++++
 rtl/rect_raster_core_rect_hit.sv | 34 +++
 rtl/rect_raster_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_rect_raster_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brus16_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : brus16_gpu_pkg
// Brief    : Shared types and constants for the brus16 rectangle raster path.
//            Holds the packed rectangle record, its field indices and the
//            capture-state encoding used by rect_raster_core.
// Revision : 1.0 - initial release
// ============================================================================
package brus16_gpu_pkg;

    localparam int WORDS_PER_RECT = 5;

    localparam logic [2:0] FIELD_X     = 3'd0;
    localparam logic [2:0] FIELD_Y     = 3'd1;
    localparam logic [2:0] FIELD_W     = 3'd2;
    localparam logic [2:0] FIELD_H     = 3'd3;
    localparam logic [2:0] FIELD_COLOR = 3'd4;

    // One rectangle as delivered by the copy controller, in stream order.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
        logic [15:0] color;
    } rect_t;

    // Word capture is either accepting words or finished until the next restart.
    typedef enum logic [0:0] {
        CAP_RUN  = 1'b0,
        CAP_DONE = 1'b1
    } cap_state_e;

    // Returns r with the selected field replaced by d.
    function automatic rect_t rect_write_field(rect_t r, logic [2:0] f, logic [15:0] d);
        rect_t o;
        o = r;
        case (f)
            FIELD_X:     o.x     = d;
            FIELD_Y:     o.y     = d;
            FIELD_W:     o.w     = d;
            FIELD_H:     o.h     = d;
            FIELD_COLOR: o.color = d;
            default:     o       = r;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_raster_core_rect_hit.sv
`default_nettype none
// ============================================================================
// Module   : rect_hit
// Brief    : Combinational coverage test of one rectangle against a pixel.
//            Edge sums are formed in 17 bits so x+width never wraps, and a
//            zero width or height can never produce a hit.
// Revision : 1.0 - initial release
// ============================================================================
module rect_hit
    import brus16_gpu_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  rect_t              rect_i,
    input  logic [COORD_W-1:0] hcount_i,
    input  logic [COORD_W-1:0] vcount_i,
    output logic               hit_o
);

    logic [16:0] h_w;
    logic [16:0] v_w;
    logic [16:0] x_end_w;
    logic [16:0] y_end_w;

    assign h_w     = 17'(hcount_i);
    assign v_w     = 17'(vcount_i);
    assign x_end_w = {1'b0, rect_i.x} + {1'b0, rect_i.w};
    assign y_end_w = {1'b0, rect_i.y} + {1'b0, rect_i.h};

    assign hit_o = (h_w >= {1'b0, rect_i.x}) && (h_w < x_end_w) &&
                   (v_w >= {1'b0, rect_i.y}) && (v_w < y_end_w);

endmodule
`default_nettype wire

// File: rtl/rect_raster_core.sv
`default_nettype none
// ============================================================================
// Module   : rect_raster_core
// Brief    : Captures the rectangle word stream into a register file and
//            resolves each pixel to the colour of the topmost covering
//            rectangle (highest index) or BG_COLOR, with a 2-cycle latency.
// Options  : RECT_DOUBLE_BUFFER_EN - when defined, words land in a shadow set
//            that is committed to the displayed set on frame_start once a
//            full set has been captured. When undefined, a single set is
//            written directly and frame_start is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rect_raster_core
    import brus16_gpu_pkg::*;
#(
    parameter int          RECT_COUNT = 64,
    parameter int          COORD_W    = 10,
    parameter logic [15:0] BG_COLOR   = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        copy_data,
    input  logic               copy_reset,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               pixel_valid,
    output logic [15:0]        pixel_color,
    output logic               pixel_color_valid,
    output logic               load_done
);

    localparam int                RIDX_W    = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
    localparam logic [RIDX_W-1:0] LAST_RECT = RIDX_W'(RECT_COUNT - 1);

    // ------------------------------------------------------------------
    // Word capture
    // ------------------------------------------------------------------
    cap_state_e        state_q, state_d;
    logic [2:0]        field_q, field_d;
    logic [RIDX_W-1:0] rect_q,  rect_d;
    logic              wr_en;
    logic              last_wr;
    logic              load_done_q, load_done_d;

    // Capture state, field and rect counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CAP_RUN;
            field_q <= '0;
            rect_q  <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            rect_q  <= rect_d;
        end
    end

    // Next capture state: one word per cycle until the last field of the last rect.
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        rect_d  = rect_q;
        wr_en   = 1'b0;
        last_wr = 1'b0;
        if (copy_reset) begin
            state_d = CAP_RUN;
            field_d = '0;
            rect_d  = '0;
        end else begin
            case (state_q)
                CAP_RUN: begin
                    wr_en = 1'b1;
                    if (field_q == FIELD_COLOR) begin
                        field_d = '0;
                        if (rect_q == LAST_RECT) begin
                            state_d = CAP_DONE;
                            last_wr = 1'b1;
                        end else begin
                            rect_d = rect_q + RIDX_W'(1);
                        end
                    end else begin
                        field_d = field_q + 3'd1;
                    end
                end
                CAP_DONE: begin
                    state_d = CAP_DONE;
                end
                default: begin
                    state_d = CAP_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Rectangle register sets
    // ------------------------------------------------------------------
    rect_t act_q [RECT_COUNT];

`ifdef RECT_DOUBLE_BUFFER_EN
    rect_t shd_q [RECT_COUNT];
    logic  commit;

    // A commit only ever copies a complete captured set.
    assign commit = frame_start && load_done_q;

    // Shadow set receives the incoming words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RECT_COUNT; i++) begin
                shd_q[i] <= '0;
            end
        end else if (wr_en) begin
            shd_q[rect_q] <= rect_write_field(shd_q[rect_q], field_q, copy_data);
        end
    end

    // Displayed set takes the whole shadow set in one cycle on commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RECT_COUNT; i++) begin
                act_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < RECT_COUNT; i++) begin
                act_q[i] <= shd_q[i];
            end
        end
    end

    // load_done holds from the last word until commit or a stream restart.
    always_comb begin
        load_done_d = load_done_q;
        if (copy_reset) begin
            load_done_d = 1'b0;
        end else if (last_wr) begin
            load_done_d = 1'b1;
        end else if (commit) begin
            load_done_d = 1'b0;
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;

    // Single set: captured words go straight into the displayed set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RECT_COUNT; i++) begin
                act_q[i] <= '0;
            end
        end else if (wr_en) begin
            act_q[rect_q] <= rect_write_field(act_q[rect_q], field_q, copy_data);
        end
    end

    // load_done is a one-cycle pulse after the last word.
    always_comb begin
        load_done_d = last_wr;
    end
`endif

    // load_done register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= load_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic [RECT_COUNT-1:0] hit_w;
    logic [RECT_COUNT-1:0] hit_q;
    logic                  valid1_q;
    logic [15:0]           col1_q [RECT_COUNT];
    logic [15:0]           color_d;
    logic [15:0]           color_q;
    logic                  color_valid_q;

    for (genvar g = 0; g < RECT_COUNT; g++) begin : g_hit
        rect_hit #(
            .COORD_W (COORD_W)
        ) u_rect_hit (
            .rect_i   (act_q[g]),
            .hcount_i (hcount),
            .vcount_i (vcount),
            .hit_o    (hit_w[g])
        );
    end

    // Stage 1: hit vector, valid, and a colour snapshot so a commit between
    // stages cannot mix old geometry with new colours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q    <= '0;
            valid1_q <= 1'b0;
            for (int i = 0; i < RECT_COUNT; i++) begin
                col1_q[i] <= '0;
            end
        end else begin
            hit_q    <= hit_w;
            valid1_q <= pixel_valid;
            for (int i = 0; i < RECT_COUNT; i++) begin
                col1_q[i] <= act_q[i].color;
            end
        end
    end

    // Stage 2 select: the highest-index hitting rect draws on top.
    always_comb begin
        color_d = BG_COLOR;
        for (int i = 0; i < RECT_COUNT; i++) begin
            if (hit_q[i]) begin
                color_d = col1_q[i];
            end
        end
        if (!valid1_q) begin
            color_d = BG_COLOR;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color_q       <= 16'h0000;
            color_valid_q <= 1'b0;
        end else begin
            color_q       <= color_d;
            color_valid_q <= valid1_q;
        end
    end

    assign pixel_color       = color_q;
    assign pixel_color_valid = color_valid_q;
    assign load_done         = load_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rect_raster_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_raster_core
// Brief    : Self-checking bench for rect_raster_core. A frame-level model
//            (word counter, shadow/active arrays, 2-deep expected-colour
//            delay line) predicts every output each cycle; directed
//            sequences add constant expectations. Honours RECT_DOUBLE_BUFFER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_raster_core;

    localparam int          N  = 8;
    localparam int          NW = 5 * N;
    localparam int          CW = 10;
    localparam logic [15:0] BG = 16'h0842;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   copy_data;
    logic          copy_reset;
    logic          frame_start;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          pixel_valid;
    logic [15:0]   pixel_color;
    logic          pixel_color_valid;
    logic          load_done;

    always #5 clk = ~clk;

    rect_raster_core #(
        .RECT_COUNT (N),
        .COORD_W    (CW),
        .BG_COLOR   (BG)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .copy_data         (copy_data),
        .copy_reset        (copy_reset),
        .frame_start       (frame_start),
        .hcount            (hcount),
        .vcount            (vcount),
        .pixel_valid       (pixel_valid),
        .pixel_color       (pixel_color),
        .pixel_color_valid (pixel_color_valid),
        .load_done         (load_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_sh  [N][5];
    logic [15:0] m_act [N][5];
    int          m_wcnt;
    bit          m_ld;
    logic [15:0] e1c, e2c;
    bit          e1v, e2v;

    logic [15:0] stim [NW];

    function automatic logic [15:0] ref_color(input int h, input int v);
        logic [15:0] c;
        c = BG;
        for (int i = 0; i < N; i++) begin
            int x, y, w, hh;
            x  = int'(m_act[i][0]);
            y  = int'(m_act[i][1]);
            w  = int'(m_act[i][2]);
            hh = int'(m_act[i][3]);
            if (h >= x && h < x + w && v >= y && v < y + hh) c = m_act[i][4];
        end
        return c;
    endfunction

    // Advance model and DUT by one clock using the currently driven inputs.
    task automatic tick();
        logic [15:0] nc;
        bit          nv;
        bit          commit;
        bit          lastw;
        nv     = pixel_valid;
        nc     = pixel_valid ? ref_color(int'(hcount), int'(vcount)) : BG;
        commit = 1'b0;
        lastw  = 1'b0;
`ifdef RECT_DOUBLE_BUFFER_EN
        commit = frame_start && m_ld;
        if (commit) m_act = m_sh;
`endif
        if (copy_reset) begin
            m_wcnt = 0;
        end else if (m_wcnt < NW) begin
`ifdef RECT_DOUBLE_BUFFER_EN
            m_sh[m_wcnt / 5][m_wcnt % 5] = copy_data;
`else
            m_act[m_wcnt / 5][m_wcnt % 5] = copy_data;
`endif
            m_wcnt++;
            lastw = (m_wcnt == NW);
        end
`ifdef RECT_DOUBLE_BUFFER_EN
        if (copy_reset)  m_ld = 1'b0;
        else if (lastw)  m_ld = 1'b1;
        else if (commit) m_ld = 1'b0;
`else
        m_ld = lastw;
`endif
        e2c = e1c; e2v = e1v;
        e1c = nc;  e1v = nv;
        @(posedge clk);
        #1;
        check_eq("pixel_color", pixel_color, e2c);
        check_eq("pixel_color_valid", pixel_color_valid, e2v);
        check_eq("load_done", load_done, m_ld);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_stim();
        for (int k = 0; k < NW; k++) stim[k] = 16'h0000;
    endtask

    task automatic set_rect(input int i, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] w, input logic [15:0] h, input logic [15:0] c);
        stim[5*i+0] = x; stim[5*i+1] = y; stim[5*i+2] = w;
        stim[5*i+3] = h; stim[5*i+4] = c;
    endtask

    // Restart capture and send the whole stim set; optional frame_start at word fs_at.
    task automatic stream_stim(input int fs_at);
        copy_reset = 1'b1;
        tick();
        copy_reset = 1'b0;
        for (int k = 0; k < NW; k++) begin
            copy_data   = stim[k];
            frame_start = (k == fs_at);
            tick();
            frame_start = 1'b0;
            if (k == NW - 2) check_eq("ld_before_last", load_done, 1'b0);
            if (k == NW - 1) check_eq("ld_after_last", load_done, 1'b1);
        end
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic probe(input int h, input int v, input logic [15:0] exp, input string tag);
        hcount      = CW'(h);
        vcount      = CW'(v);
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        tick();
        check_eq(tag, pixel_color, exp);
    endtask

    function automatic logic [15:0] rand_word(input int field);
        if ($urandom % 16 == 0) return 16'($urandom);
        case (field)
            0, 1:    return 16'($urandom % 64);
            2, 3:    return 16'($urandom % 24);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset       = 1'b0;
        copy_data   = '0;
        copy_reset  = 1'b1;
        frame_start = 1'b0;
        hcount      = '0;
        vcount      = '0;
        pixel_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pixel_color", pixel_color, 16'h0000);
        check_eq("rst_pixel_valid", pixel_color_valid, 1'b0);
        check_eq("rst_load_done", load_done, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < N; i++)
            for (int f = 0; f < 5; f++) begin
                m_sh[i][f]  = 16'h0000;
                m_act[i][f] = 16'h0000;
            end
        m_wcnt = 0;
        m_ld   = 1'b0;
        e1c    = BG;  e1v = 1'b0;
        e2c    = 16'h0000; e2v = 1'b0;

        // Empty set after reset.
        probe(5, 5, BG, "reset_bg");

        // Single rect.
        clear_stim();
        set_rect(0, 16'd10, 16'd20, 16'd4, 16'd3, 16'hF800);
        stream_stim(-1);
        frame_pulse();
        probe(13, 22, 16'hF800, "single_inside");
        probe(14, 22, BG, "single_right_edge");
        probe(10, 23, BG, "single_bottom_edge");

        // Overlap: later rect on top.
        clear_stim();
        set_rect(0, 16'd0,  16'd0,  16'd100, 16'd100, 16'h001F);
        set_rect(1, 16'd50, 16'd50, 16'd10,  16'd10,  16'h07E0);
        stream_stim(-1);
        frame_pulse();
        probe(55, 55, 16'h07E0, "overlap_top");
        probe(20, 20, 16'h001F, "overlap_bottom");

        // Restart after 7 words; early frame_start must not commit.
        clear_stim();
        set_rect(0, 16'd0, 16'd0, 16'd200, 16'd200, 16'hABCD);
        copy_reset = 1'b1;
        tick();
        copy_reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            copy_data = stim[k];
            tick();
        end
        check_eq("partial_ld", load_done, 1'b0);
        copy_reset = 1'b1;
        frame_pulse();
        check_eq("partial_ld_after_fs", load_done, 1'b0);
`ifdef RECT_DOUBLE_BUFFER_EN
        probe(55, 55, 16'h07E0, "partial_no_commit");
`else
        probe(55, 55, 16'hABCD, "partial_direct");
`endif
        stream_stim(-1);
        frame_pulse();
        probe(55, 55, 16'hABCD, "restart_full");

        // frame_start on the last word: commit deferred to next frame.
        clear_stim();
        set_rect(0, 16'd30, 16'd30, 16'd5, 16'd5, 16'h1234);
        stream_stim(NW - 1);
`ifdef RECT_DOUBLE_BUFFER_EN
        probe(32, 32, 16'hABCD, "fs_last_no_commit");
        check_eq("fs_last_ld_held", load_done, 1'b1);
`else
        probe(32, 32, 16'h1234, "fs_last_direct");
`endif
        frame_pulse();
        check_eq("commit_ld_clear", load_done, 1'b0);
        probe(32, 32, 16'h1234, "fs_next_commit");

        // No 16-bit wrap of x+width.
        clear_stim();
        set_rect(0, 16'hFFF0, 16'd0, 16'h0020, 16'd1, 16'hFFFF);
        set_rect(1, 16'd0,    16'd0, 16'd4,    16'd1, 16'h5555);
        stream_stim(-1);
        frame_pulse();
        probe(5, 0, BG, "wrap_bg");
        probe(2, 0, 16'h5555, "wrap_neighbour");

        // Randomized traffic against the model.
        copy_reset = 1'b1;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            copy_reset  = ($urandom % 64 == 0);
            copy_data   = rand_word(m_wcnt % 5);
            frame_start = ($urandom % 20 == 0);
            hcount      = CW'($urandom % 80);
            vcount      = CW'($urandom % 80);
            pixel_valid = ($urandom % 4 != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
